// File: rtl/single_predict_pkg.sv
// Shared fp32 definitions for the single_predict result path.
// Provides the fp32 word type, a few encoding constants and the function that
// maps fp32 bit patterns onto an unsigned key whose integer order follows the
// numeric order of the scores.
package single_predict_pkg;

  localparam int FP32_W = 32;
  localparam logic [7:0] FP32_NAN_EXP = 8'hFF;
  localparam logic [FP32_W-1:0] FP32_NEG_ZERO = 32'h8000_0000;

  typedef logic [FP32_W-1:0] fp32_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } state_t;

  // Unsigned ordering key: positive values get the sign bit set so they sort
  // above every negative value. Negative values are bit-inverted so that a
  // larger magnitude gives a smaller key. -0 is folded onto +0 so the two
  // compare equal. NaN is pinned to the minimum so it never wins.
  function automatic logic [FP32_W-1:0] fp32_order_key(input fp32_t v);
    fp32_t b;
    b = (v == FP32_NEG_ZERO) ? '0 : v;
    if ((b[30:23] == FP32_NAN_EXP) && (b[22:0] != '0)) begin
      return '0;
    end else if (!b[31]) begin
      return b ^ 32'h8000_0000;
    end else begin
      return ~b;
    end
  endfunction

endpackage

// File: rtl/single_predict_result.sv
// single_predict_result
// Consumer of single_predict's done pulse. Snapshots the fp32 score vector,
// walks it one element per clock to find the argmax, reports the winning class
// and value, scores it against the supplied label and keeps running counters.
//
// Ports
//   clk            system clock, posedge
//   rstn           asynchronous active-low reset
//   done           1-cycle pulse, y and label valid in the same cycle
//   y              OUTPUT_NODES x fp32 scores
//   label          expected class, sampled with done
//   clear_stats    synchronous clear of total/correct counters and overrun
//   busy           high while a scan is in progress
//   result_valid   1-cycle pulse, class_idx/class_value/correct valid and held
//   class_idx      index of the maximum score
//   class_value    fp32 bits of the maximum score
//   correct        class_idx matched the latched label
//   total_count    results scored since reset/clear (saturating)
//   correct_count  correct results since reset/clear (saturating)
//   overrun        sticky: a done arrived during a scan and was dropped
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_IDLE | waiting for done; a done here captures y/label and starts a scan
// ST_SCAN | comparing snap[idx] against the running best, one per clock
module single_predict_result
  import single_predict_pkg::*;
#(
  parameter int OUTPUT_NODES = 10,
  parameter int COUNT_W      = 32,
  parameter int IDX_W        = $clog2(OUTPUT_NODES)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               done,
  input  fp32_t              y [OUTPUT_NODES],
  input  logic [IDX_W-1:0]   label,
  input  logic               clear_stats,
  output logic               busy,
  output logic               result_valid,
  output logic [IDX_W-1:0]   class_idx,
  output fp32_t              class_value,
  output logic               correct,
  output logic [COUNT_W-1:0] total_count,
  output logic [COUNT_W-1:0] correct_count,
  output logic               overrun
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OUTPUT_NODES - 1);

  state_t            state_q, state_d;
  fp32_t             snap_q [OUTPUT_NODES];
  logic [IDX_W-1:0]  label_q;
  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  best_idx_q;
  fp32_t             best_val_q;
  logic [FP32_W-1:0] best_key_q;

  fp32_t             cur_val;
  logic [FP32_W-1:0] cur_key;
  logic              take;
  logic [IDX_W-1:0]  cand_idx;
  fp32_t             cand_val;
  logic [FP32_W-1:0] cand_key;
  logic              last;
  logic              cand_correct;

  // Explicit mux keeps the select in range for non-power-of-two OUTPUT_NODES.
  always_comb begin
    cur_val = '0;
    for (int i = 0; i < OUTPUT_NODES; i++) begin
      if (idx_q == IDX_W'(i)) cur_val = snap_q[i];
    end
  end

  // Strict compare: on a tie the earlier (lower) index stays best.
  always_comb begin
    cur_key      = fp32_order_key(cur_val);
    take         = (cur_key > best_key_q);
    cand_idx     = take ? idx_q   : best_idx_q;
    cand_val     = take ? cur_val : best_val_q;
    cand_key     = take ? cur_key : best_key_q;
    last         = (idx_q == LAST_IDX);
    cand_correct = (cand_idx == label_q) && (int'(label_q) < OUTPUT_NODES);
  end

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (done) state_d = ST_SCAN;
      ST_SCAN: if (last) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q == ST_SCAN);
  end

  // Snapshot and scan datapath
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < OUTPUT_NODES; i++) snap_q[i] <= '0;
      label_q      <= '0;
      idx_q        <= '0;
      best_idx_q   <= '0;
      best_val_q   <= '0;
      best_key_q   <= '0;
      result_valid <= 1'b0;
      class_idx    <= '0;
      class_value  <= '0;
      correct      <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      if (state_q == ST_IDLE) begin
        if (done) begin
          for (int i = 0; i < OUTPUT_NODES; i++) snap_q[i] <= y[i];
          label_q    <= label;
          best_idx_q <= '0;
          best_val_q <= y[0];
          best_key_q <= fp32_order_key(y[0]);
          idx_q      <= IDX_W'(1);
        end
      end else begin
        best_idx_q <= cand_idx;
        best_val_q <= cand_val;
        best_key_q <= cand_key;
        idx_q      <= idx_q + IDX_W'(1);
        if (last) begin
          class_idx    <= cand_idx;
          class_value  <= cand_val;
          correct      <= cand_correct;
          result_valid <= 1'b1;
        end
      end
    end
  end

  // Statistics: scored in the result_valid cycle; clear_stats takes priority.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      total_count   <= '0;
      correct_count <= '0;
      overrun       <= 1'b0;
    end else if (clear_stats) begin
      total_count   <= '0;
      correct_count <= '0;
      overrun       <= 1'b0;
    end else begin
      if (result_valid) begin
        if (total_count != '1) total_count <= total_count + COUNT_W'(1);
        if (correct && (correct_count != '1)) correct_count <= correct_count + COUNT_W'(1);
      end
      if ((state_q == ST_SCAN) && done) overrun <= 1'b1;
    end
  end

endmodule

// File: tb/tb_single_predict_result.sv
module tb_single_predict_result;

  localparam int N = 10;

  logic        clk;
  logic        rstn;
  logic        done;
  logic [31:0] y_in [N];
  logic [3:0]  label;
  logic        clear_stats;
  logic        busy;
  logic        result_valid;
  logic [3:0]  class_idx;
  logic [31:0] class_value;
  logic        correct;
  logic [31:0] total_count;
  logic [31:0] correct_count;
  logic        overrun;

  single_predict_result #(.OUTPUT_NODES(N), .COUNT_W(32), .IDX_W(4)) dut (
    .clk(clk), .rstn(rstn), .done(done), .y(y_in), .label(label),
    .clear_stats(clear_stats), .busy(busy), .result_valid(result_valid),
    .class_idx(class_idx), .class_value(class_value), .correct(correct),
    .total_count(total_count), .correct_count(correct_count), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0][31:0] y;
    logic [3:0]         label;
    logic [3:0]         exp_idx;
    logic [31:0]        exp_val;
    logic               exp_corr;
  } vec_t;

  vec_t vecs [6];
  int   checks = 0;
  int   errors = 0;
  int   m_total = 0;
  int   m_corr  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load_y(input logic [N-1:0][31:0] v);
    for (int i = 0; i < N; i++) y_in[i] = v[i];
  endtask

  task automatic pulse_done();
    @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
  endtask

  // Returns number of edges after the done-sampling edge until result_valid, or -1.
  task automatic wait_result(output int edges, output logic busy_mid);
    edges = -1;
    busy_mid = 1'b0;
    for (int e = 1; e <= 30; e++) begin
      @(posedge clk); #1;
      if (e == 4) busy_mid = busy;
      if (result_valid) begin
        edges = e;
        break;
      end
    end
  endtask

  task automatic run_vec(input int k);
    int   edges;
    logic bm;
    load_y(vecs[k].y);
    label = vecs[k].label;
    pulse_done();
    wait_result(edges, bm);
    chk($sformatf("v%0d latency", k), edges, 9);
    chk($sformatf("v%0d busy_mid", k), {31'b0, bm}, 1);
    chk($sformatf("v%0d busy_end", k), {31'b0, busy}, 0);
    chk($sformatf("v%0d class_idx", k), {28'b0, class_idx}, {28'b0, vecs[k].exp_idx});
    chk($sformatf("v%0d class_value", k), class_value, vecs[k].exp_val);
    chk($sformatf("v%0d correct", k), {31'b0, correct}, {31'b0, vecs[k].exp_corr});
    m_total++;
    if (vecs[k].exp_corr) m_corr++;
    @(posedge clk); #1;
    chk($sformatf("v%0d rv_pulse", k), {31'b0, result_valid}, 0);
    chk($sformatf("v%0d total", k), total_count, m_total);
    chk($sformatf("v%0d correct_cnt", k), correct_count, m_corr);
  endtask

  initial begin
    int   edges;
    int   nres;
    logic bm;

    // Table: cumulative counts are tracked by the m_total/m_corr model.
    for (int i = 0; i < N; i++) vecs[0].y[i] = 32'h3DCC_CCCD;
    vecs[0].y[7] = 32'h3F80_0000;
    vecs[0].label = 4'd7; vecs[0].exp_idx = 4'd7; vecs[0].exp_val = 32'h3F80_0000; vecs[0].exp_corr = 1'b1;

    vecs[1].y[0] = 32'hBF80_0000; vecs[1].y[1] = 32'hC000_0000; vecs[1].y[2] = 32'hC040_0000;
    vecs[1].y[3] = 32'hC080_0000; vecs[1].y[4] = 32'hC0A0_0000; vecs[1].y[5] = 32'hC0C0_0000;
    vecs[1].y[6] = 32'hC0E0_0000; vecs[1].y[7] = 32'hC100_0000; vecs[1].y[8] = 32'hC110_0000;
    vecs[1].y[9] = 32'hC120_0000;
    vecs[1].label = 4'd3; vecs[1].exp_idx = 4'd0; vecs[1].exp_val = 32'hBF80_0000; vecs[1].exp_corr = 1'b0;

    for (int i = 0; i < N; i++) vecs[2].y[i] = 32'h0;
    vecs[2].y[2] = 32'h4000_0000; vecs[2].y[5] = 32'h4000_0000;
    vecs[2].label = 4'd2; vecs[2].exp_idx = 4'd2; vecs[2].exp_val = 32'h4000_0000; vecs[2].exp_corr = 1'b1;

    for (int i = 0; i < N; i++) vecs[3].y[i] = 32'hBF80_0000;
    vecs[3].y[0] = 32'h7FC0_0000; vecs[3].y[1] = 32'h8000_0000; vecs[3].y[2] = 32'h0000_0000;
    vecs[3].label = 4'd2; vecs[3].exp_idx = 4'd1; vecs[3].exp_val = 32'h8000_0000; vecs[3].exp_corr = 1'b0;

    // +inf in the last slot beats max finite
    for (int i = 0; i < N; i++) vecs[4].y[i] = 32'h7F7F_FFFF;
    vecs[4].y[9] = 32'h7F80_0000;
    vecs[4].label = 4'd9; vecs[4].exp_idx = 4'd9; vecs[4].exp_val = 32'h7F80_0000; vecs[4].exp_corr = 1'b1;

    // -inf beats every NaN; out-of-range label is never correct
    for (int i = 0; i < N; i++) vecs[5].y[i] = (i % 2 == 0) ? 32'hFFC0_0000 : 32'h7FC0_0001;
    vecs[5].y[0] = 32'hFF80_0000;
    vecs[5].label = 4'd15; vecs[5].exp_idx = 4'd0; vecs[5].exp_val = 32'hFF80_0000; vecs[5].exp_corr = 1'b0;

    rstn = 1'b0; done = 1'b0; label = '0; clear_stats = 1'b0;
    for (int i = 0; i < N; i++) y_in[i] = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", {31'b0, busy}, 0);
    chk("rst result_valid", {31'b0, result_valid}, 0);
    chk("rst class_idx", {28'b0, class_idx}, 0);
    chk("rst class_value", class_value, 0);
    chk("rst correct", {31'b0, correct}, 0);
    chk("rst total", total_count, 0);
    chk("rst correct_cnt", correct_count, 0);
    chk("rst overrun", {31'b0, overrun}, 0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("post_rst busy", {31'b0, busy}, 0);
    chk("post_rst total", total_count, 0);
    chk("post_rst class_value", class_value, 0);

    for (int k = 0; k < 6; k++) run_vec(k);

    // Second done 3 cycles into a scan is dropped and flagged.
    load_y(vecs[0].y);
    label = 4'd7;
    pulse_done();
    repeat (3) @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    nres = 0;
    for (int c = 0; c < 25; c++) begin
      @(posedge clk); #1;
      if (result_valid) nres++;
    end
    m_total++; m_corr++;
    chk("ovr result_count", nres, 1);
    chk("ovr overrun", {31'b0, overrun}, 1);
    chk("ovr total", total_count, m_total);
    chk("ovr class_idx", {28'b0, class_idx}, 7);

    @(negedge clk);
    clear_stats = 1'b1;
    @(negedge clk);
    clear_stats = 1'b0;
    m_total = 0; m_corr = 0;
    chk("clr total", total_count, 0);
    chk("clr correct_cnt", correct_count, 0);
    chk("clr overrun", {31'b0, overrun}, 0);
    chk("clr keeps class_idx", {28'b0, class_idx}, 7);
    chk("clr keeps class_value", class_value, 32'h3F80_0000);
    chk("clr keeps correct", {31'b0, correct}, 1);

    // clear_stats coincident with result_valid: that result is not counted.
    load_y(vecs[2].y);
    label = 4'd2;
    pulse_done();
    wait_result(edges, bm);
    chk("coinc latency", edges, 9);
    @(negedge clk);
    clear_stats = 1'b1;
    @(negedge clk);
    clear_stats = 1'b0;
    chk("coinc total", total_count, 0);
    chk("coinc correct_cnt", correct_count, 0);
    chk("coinc class_idx", {28'b0, class_idx}, 2);

    // Reset mid-scan abandons the scan.
    run_vec(1);
    load_y(vecs[0].y);
    label = 4'd7;
    pulse_done();
    repeat (4) @(negedge clk);
    rstn = 1'b0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    m_total = 0; m_corr = 0;
    #1;
    chk("midrst busy", {31'b0, busy}, 0);
    chk("midrst total", total_count, 0);
    chk("midrst correct_cnt", correct_count, 0);
    chk("midrst class_idx", {28'b0, class_idx}, 0);
    nres = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (result_valid) nres++;
    end
    chk("midrst no_result", nres, 0);
    run_vec(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
